// File: rtl/spi_slave_core.sv
// SPI slave byte engine: samples sclk/sin/cs_n in the clk domain, all four modes.
// Define SPI_SLAVE_CORE_SYNC_EN for a 2-flop synchronizer on the SPI inputs.
module spi_slave_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sin,
    input  logic       cs_n,
    output logic       sout,
    input  logic       polarity,
    input  logic       phase,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic       tx_underflow
);

    logic       w_sclk;
    logic       w_sin;
    logic       w_cs_n;
    logic       w_pipe_live;

`ifdef SPI_SLAVE_CORE_SYNC_EN
    logic [1:0] r_sclk_sync;
    logic [1:0] r_sin_sync;
    logic [1:0] r_cs_sync;
    logic [1:0] r_fill;

    // two-flop synchronizer; r_fill marks when real samples reach the end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= {2{polarity}};
            r_sin_sync  <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_fill      <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], sclk};
            r_sin_sync  <= {r_sin_sync[0], sin};
            r_cs_sync   <= {r_cs_sync[0], cs_n};
            r_fill      <= {r_fill[0], 1'b1};
        end
    end

    assign w_sclk      = r_sclk_sync[1];
    assign w_sin       = r_sin_sync[1];
    assign w_cs_n      = r_cs_sync[1];
    assign w_pipe_live = r_fill[1];
`else
    logic r_sclk_q;
    logic r_sin_q;
    logic r_cs_q;
    logic r_fill;

    // single register stage; r_fill marks when a real sample is present
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_q <= polarity;
            r_sin_q  <= 1'b0;
            r_cs_q   <= 1'b1;
            r_fill   <= 1'b0;
        end else begin
            r_sclk_q <= sclk;
            r_sin_q  <= sin;
            r_cs_q   <= cs_n;
            r_fill   <= 1'b1;
        end
    end

    assign w_sclk      = r_sclk_q;
    assign w_sin       = r_sin_q;
    assign w_cs_n      = r_cs_q;
    assign w_pipe_live = r_fill;
`endif

    logic       r_sclk_prev;
    logic       r_cs_prev;
    logic       r_armed;
    logic       r_cpol;
    logic       r_cpha;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic [7:0] r_tx_buf;
    logic       r_tx_full;
    logic [7:0] r_tx_shift;
    logic       r_tx_uflow;

    logic       w_active;
    logic       w_edge;
    logic       w_lead;
    logic       w_trail;
    logic       w_samp;
    logic       w_drive;
    logic       w_cs_fall;
    logic       w_last;
    logic       w_consume;

    // a frame only counts once cs_n has been seen high after reset
    assign w_active  = r_armed & ~w_cs_n;
    assign w_edge    = w_active & (w_sclk ^ r_sclk_prev);
    assign w_lead    = w_edge & (w_sclk != r_cpol);
    assign w_trail   = w_edge & (w_sclk == r_cpol);
    assign w_samp    = r_cpha ? w_trail : w_lead;
    assign w_drive   = r_cpha ? w_lead : w_trail;
    assign w_cs_fall = r_armed & r_cs_prev & ~w_cs_n;
    assign w_last    = w_samp & (r_bit_cnt == 3'd7);
    assign w_consume = w_cs_fall | w_last;

    // edge history, frame arming and mode capture while deselected
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_prev <= polarity;
            r_cs_prev   <= 1'b1;
            r_armed     <= 1'b0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs_n;
            if (w_cs_n && w_pipe_live) begin
                r_armed <= 1'b1;
            end
            if (w_cs_n) begin
                r_cpol <= polarity;
                r_cpha <= phase;
            end
        end
    end

    // receive shifter; deselect drops any partial byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_cs_n) begin
                r_bit_cnt  <= 3'd0;
                r_rx_shift <= 8'h00;
            end else if (w_samp) begin
                r_rx_shift <= {r_rx_shift[6:0], w_sin};
                if (r_bit_cnt == 3'd7) begin
                    r_rx_data  <= {r_rx_shift[6:0], w_sin};
                    r_rx_valid <= 1'b1;
                    r_bit_cnt  <= 3'd0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
        end
    end

    // tx buffer; a new load wins over a same-cycle consume
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_buf  <= 8'h00;
            r_tx_full <= 1'b0;
        end else begin
            if (tx_load && !r_tx_full) begin
                r_tx_buf  <= tx_data;
                r_tx_full <= 1'b1;
            end else if (w_consume) begin
                r_tx_buf  <= 8'h00;
                r_tx_full <= 1'b0;
            end
        end
    end

    // transmit shifter; reload at frame start and after every byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_shift <= 8'h00;
            r_tx_uflow <= 1'b0;
        end else begin
            r_tx_uflow <= 1'b0;
            if (w_consume) begin
                r_tx_shift <= r_tx_full ? r_tx_buf : 8'h00;
                r_tx_uflow <= ~r_tx_full;
            end else if (w_drive && (r_bit_cnt != 3'd0)) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
        end
    end

    assign sout         = r_tx_shift[7];
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign tx_ready     = ~r_tx_full;
    assign tx_underflow = r_tx_uflow;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: SPI master model plus byte-level expectations.
// Directed mode/underflow/abort/reset cases followed by randomized frames.
module tb_spi_slave_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       sin;
    logic       cs_n;
    logic       sout;
    logic       polarity;
    logic       phase;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic       tx_underflow;

    int total = 0;
    int bad   = 0;
    int fno   = 0;
    int rv_cnt = 0;
    int uf_cnt = 0;
    logic [7:0] rxq[$];

    spi_slave_core dut (
        .clk(clk),
        .rst(rst),
        .sclk(sclk),
        .sin(sin),
        .cs_n(cs_n),
        .sout(sout),
        .polarity(polarity),
        .phase(phase),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_load(tx_load),
        .tx_ready(tx_ready),
        .tx_underflow(tx_underflow)
    );

    always #5 clk = ~clk;

    // collect received bytes and pulse counts away from the active edge
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rv_cnt++;
            rxq.push_back(rx_data);
        end
        if (tx_underflow === 1'b1) uf_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic bit_cycle(input bit cpol, input int h, input bit b);
        sin = b;
        repeat (h) @(negedge clk);
        sclk = ~cpol;
        repeat (h) @(negedge clk);
        sclk = cpol;
    endtask

    // one master frame; the expectations follow the byte-level rules:
    // tx byte k goes out in slot k, empty slots send 0x00 and each
    // empty reload (frame start or byte end) is one underflow pulse
    task automatic run_frame(input bit cpol, input bit cpha, input int h,
                             input int nbits, input logic [7:0] mosi[$],
                             input logic [7:0] txq[$]);
        logic [7:0] miso[$];
        logic [7:0] rb;
        logic [7:0] cur;
        logic [7:0] prev_rx;
        logic [7:0] exp_b;
        int nfull, ntx, rv0, uf0, uf_fall, idx;
        bit done;
        fno++;
        nfull = nbits / 8;
        ntx = txq.size();
        rb = 8'h00;
        done = 1'b0;
        idx = 1;
        rxq.delete();
        polarity = cpol;
        phase = cpha;
        sclk = cpol;
        cs_n = 1'b1;
        repeat (h) @(negedge clk);
        chk($sformatf("f%0d_ready_pre", fno), tx_ready, 1);
        if (ntx > 0) load(txq[0]);
        repeat (4) @(negedge clk);
        prev_rx = rx_data;
        rv0 = rv_cnt;
        uf0 = uf_cnt;
        cs_n = 1'b0;
        fork
            begin
                repeat (h) @(negedge clk);
                uf_fall = uf_cnt - uf0;
                for (int i = 0; i < nbits; i++) begin
                    cur = mosi[i / 8];
                    if (!cpha) begin
                        sin = cur[7 - (i % 8)];
                        repeat (h) @(negedge clk);
                        sclk = ~cpol;
                        rb = {rb[6:0], sout};
                        repeat (h) @(negedge clk);
                        sclk = cpol;
                    end else begin
                        sclk = ~cpol;
                        sin = cur[7 - (i % 8)];
                        repeat (h) @(negedge clk);
                        sclk = cpol;
                        rb = {rb[6:0], sout};
                        repeat (h) @(negedge clk);
                    end
                    if ((i % 8) == 7) miso.push_back(rb);
                end
                repeat (h) @(negedge clk);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (tx_load) begin
                        tx_load = 1'b0;
                    end else if (idx < ntx && tx_ready) begin
                        tx_data = txq[idx];
                        tx_load = 1'b1;
                        idx++;
                    end
                end
                tx_load = 1'b0;
            end
        join
        cs_n = 1'b1;
        repeat (h) @(negedge clk);
        chk($sformatf("f%0d_rv_cnt", fno), rv_cnt - rv0, nfull);
        chk($sformatf("f%0d_uf_fall", fno), uf_fall, (ntx == 0) ? 1 : 0);
        chk($sformatf("f%0d_uf_tot", fno), uf_cnt - uf0, nfull + 1 - ntx);
        for (int j = 0; j < nfull; j++) begin
            chk($sformatf("f%0d_rx%0d", fno, j),
                (rxq.size() > j) ? {24'h0, rxq[j]} : 32'hDEAD, mosi[j]);
            exp_b = (j < ntx) ? txq[j] : 8'h00;
            chk($sformatf("f%0d_miso%0d", fno, j),
                (miso.size() > j) ? {24'h0, miso[j]} : 32'hDEAD, exp_b);
        end
        chk($sformatf("f%0d_rx_data", fno), rx_data,
            (nfull > 0) ? mosi[nfull - 1] : prev_rx);
    endtask

    initial begin
        logic [7:0] mq[$];
        logic [7:0] tq[$];
        int n, ntx, part, rv0;
        bit cp, ch;
        rst = 1'b0;
        sclk = 1'b0;
        sin = 1'b0;
        cs_n = 1'b1;
        polarity = 1'b0;
        phase = 1'b0;
        tx_data = 8'h00;
        tx_load = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sout", sout, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_tx_uflow", tx_underflow, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        mq = {8'hA5}; tq = {8'h3C};
        run_frame(0, 0, 50, 8, mq, tq);
        mq = {8'h7E}; tq = {8'h81};
        run_frame(1, 1, 6, 8, mq, tq);
        mq = {8'h11, 8'h22}; tq = {8'hC3, 8'h5A};
        run_frame(0, 0, 5, 16, mq, tq);
        mq = {8'hFF}; tq = {};
        run_frame(0, 0, 5, 8, mq, tq);
        mq = {8'hC5}; tq = {};
        run_frame(0, 0, 5, 3, mq, tq);
        mq = {8'h96}; tq = {};
        run_frame(0, 0, 5, 8, mq, tq);

        // reset in the middle of a byte
        polarity = 1'b0;
        phase = 1'b0;
        sclk = 1'b0;
        cs_n = 1'b1;
        repeat (5) @(negedge clk);
        load(8'hF0);
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
        load(8'h55);
        for (int i = 0; i < 3; i++) bit_cycle(0, 5, 1'b1);
        repeat (5) @(negedge clk);
        chk("pre_rst_sout", sout, 1);
        chk("pre_rst_ready", tx_ready, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_sout", sout, 0);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_tx_ready", tx_ready, 1);
        chk("mid_rst_tx_uflow", tx_underflow, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rv0 = rv_cnt;
        for (int i = 0; i < 8; i++) bit_cycle(0, 5, i[0]);
        repeat (5) @(negedge clk);
        chk("post_rst_no_rv", rv_cnt - rv0, 0);
        cs_n = 1'b1;
        mq = {8'h5A}; tq = {};
        run_frame(0, 0, 5, 8, mq, tq);

        for (int r = 0; r < 12; r++) begin
            cp = 1'($urandom_range(0, 1));
            ch = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            ntx = $urandom_range(0, n);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            mq = {};
            tq = {};
            for (int k = 0; k < n + ((part > 0) ? 1 : 0); k++)
                mq.push_back(8'($urandom));
            for (int k = 0; k < ntx; k++)
                tq.push_back(8'($urandom));
            run_frame(cp, ch, $urandom_range(4, 8), 8 * n + part, mq, tq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
